// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the dmem_ctrl load/store data memory.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dmem_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  // Controller state: INIT sweeps the array to zero, RUN serves requests
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One response pipeline slot
  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  // Byte-enable mask for an access of the given size at the given byte lane
  function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: replicates store data into lanes with byte-enables, extracts and extends loads.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] wdata_lane,
  output logic [3:0]  be,
  input  logic [31:0] rword,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign be    = be_from(size, lane);
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  // Store path: replicate the right-aligned data so whichever lanes are enabled see it
  always_comb begin
    wdata_lane = wdata;
    case (size)
      SZ_B:    wdata_lane = {4{wdata[7:0]}};
      SZ_H:    wdata_lane = {2{wdata[15:0]}};
      default: wdata_lane = wdata;
    endcase
  end

  // Load path: pick the addressed byte/half and sign- or zero-extend; words pass through
  always_comb begin
    rdata = '0;
    case (size)
      SZ_B:    rdata = uns ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      SZ_H:    rdata = uns ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      SZ_W:    rdata = rword;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Word-organised data memory with byte/half/word load-store front end and zeroing sweep after reset.
// Latency: response exactly RD_LAT cycles after acceptance; one request accepted per cycle.
// Backpressure: req_ready low only while the INIT sweep runs; no backpressure on responses.
// Optional debug read port enabled by defining DMEM_DBG_PORT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DEPTH_WORDS = 256,
  parameter  int RD_LAT      = 1,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
`ifdef DMEM_DBG_PORT_EN
  ,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [31:0]       dbg_rdata
`endif
);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [0:0]       state;
  logic [IDX_W-1:0] sweep_cnt;

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             acc;
  logic             hi_err;
  logic             acc_err;
  logic             wr_en;
  logic [31:0]      rword;
  logic [31:0]      wdata_lane;
  logic [3:0]       be;
  logic [31:0]      load_data;

  rsp_t             stage_in;
  rsp_t             pipe [RD_LAT];

  assign req_ready = (state == ST_RUN);
  assign init_done = (state == ST_RUN);

  assign idx    = req_addr[IDX_W+1:2];
  assign lane   = req_addr[1:0];
  assign acc    = req_valid && req_ready;
  assign hi_err = (req_addr >> (IDX_W + 2)) != '0;

  assign acc_err = (req_size == SZ_RSV)
                || ((req_size == SZ_H) && lane[0])
                || ((req_size == SZ_W) && (lane != 2'b00))
                || hi_err;

  assign wr_en = acc && req_we && !acc_err;

  // Asynchronous array read: data is captured into the pipeline at acceptance,
  // so a load right after a store to the same word sees the stored value.
  assign rword = mem[idx];

  dmem_lane_align u_align (
    .size       (req_size),
    .lane       (lane),
    .uns        (req_unsigned),
    .wdata      (req_wdata),
    .wdata_lane (wdata_lane),
    .be         (be),
    .rword      (rword),
    .rdata      (load_data)
  );

  // Sweep FSM: zero every word once after reset, then serve requests
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (sweep_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
        state <= ST_RUN;
      end
    end
  end

  // Array writes: sweep zeroing in INIT, byte-enabled stores in RUN, nothing on a reset edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[sweep_cnt] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
          end
        end
      end
    end
  end

  // Response slot for this cycle's acceptance; stores and errors return zero data
  always_comb begin
    stage_in     = '0;
    stage_in.vld = acc;
    stage_in.err = acc && acc_err;
    stage_in.dat = (acc && !acc_err && !req_we) ? load_data : 32'h0;
  end

  // Fixed-length response pipeline; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= stage_in;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rsp_valid = pipe[RD_LAT-1].vld;
  assign rsp_err   = pipe[RD_LAT-1].err;
  assign rsp_rdata = pipe[RD_LAT-1].dat;

`ifdef DMEM_DBG_PORT_EN
  // Registered side-band peek at any word, independent of the request port
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_rdata <= '0;
    end else begin
      dbg_rdata <= mem[dbg_addr];
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, back-to-back and reset corner cases,
// and randomized traffic scored against a byte-array reference model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int RD_LAT = 3;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH),
    .RD_LAT      (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  typedef struct {
    int          due;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  exp_t        mon_x;
  logic [7:0]  mbytes [DEPTH*4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory, access legality from size/alignment/range
  task automatic model_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic err, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((a % n) != 0) || (a >= 32'(DEPTH * 4));
    rd  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mbytes[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[a + i];
        if (!uns && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
      end
    end
  endtask

  // Monitor: score responses against the model queue, then record this cycle's acceptance
  always @(negedge clk) begin
    logic        m_err;
    logic [31:0] m_rd;
    ncyc++;
    if (rsp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        check("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
      end else begin
        mon_e = expq.pop_front();
        check("rsp_latency", 32'(ncyc), 32'(mon_e.due));
        check("rsp_rdata", rsp_rdata, mon_e.dat);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
      end
    end else if (expq.size() > 0 && expq[0].due <= ncyc) begin
      mon_e = expq.pop_front();
      check("rsp_missing", {31'h0, rsp_valid}, 32'h1);
    end
    if (rst) begin
      expq.delete();
      for (int i = 0; i < DEPTH * 4; i++) mbytes[i] = 8'h0;
    end else if (req_valid && req_ready === 1'b1) begin
      model_req(req_we, req_size, req_unsigned, req_addr, req_wdata, m_err, m_rd);
      mon_x.due = ncyc + RD_LAT;
      mon_x.dat = m_rd;
      mon_x.err = m_err;
      expq.push_back(mon_x);
    end
  end

  // Present one request for one cycle; called and returns at posedge+1
  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [31:0] ed, input logic ee);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid !== 1'b1 && n < 20);
    check({name, "_lat"}, 32'(n), 32'(RD_LAT));
    check({name, "_dat"}, rsp_rdata, ed);
    check({name, "_err"}, {31'h0, rsp_err}, {31'h0, ee});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    check({name, "_cycles"}, 32'(n), 32'(DEPTH));
    check({name, "_done"}, {31'h0, init_done}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t        vt [18];
  logic        bv [8];
  logic [31:0] bd [8];
  int          nrsp;

  initial begin
    vt[0]  = '{1'b0, SZ_W,   1'b0, 32'h040, 32'h0,         32'h0,         1'b0};
    vt[1]  = '{1'b1, SZ_W,   1'b0, 32'h010, 32'h11223344,  32'h0,         1'b0};
    vt[2]  = '{1'b1, SZ_B,   1'b0, 32'h012, 32'h000000AA,  32'h0,         1'b0};
    vt[3]  = '{1'b0, SZ_W,   1'b0, 32'h010, 32'h0,         32'h11AA3344,  1'b0};
    vt[4]  = '{1'b0, SZ_B,   1'b0, 32'h012, 32'h0,         32'hFFFFFFAA,  1'b0};
    vt[5]  = '{1'b0, SZ_B,   1'b1, 32'h012, 32'h0,         32'h000000AA,  1'b0};
    vt[6]  = '{1'b1, SZ_H,   1'b0, 32'h022, 32'h00008001,  32'h0,         1'b0};
    vt[7]  = '{1'b0, SZ_H,   1'b0, 32'h022, 32'h0,         32'hFFFF8001,  1'b0};
    vt[8]  = '{1'b0, SZ_H,   1'b1, 32'h022, 32'h0,         32'h00008001,  1'b0};
    vt[9]  = '{1'b0, SZ_W,   1'b0, 32'h020, 32'h0,         32'h80010000,  1'b0};
    vt[10] = '{1'b0, SZ_W,   1'b0, 32'h013, 32'h0,         32'h0,         1'b1};
    vt[11] = '{1'b1, SZ_H,   1'b0, 32'h021, 32'h00005555,  32'h0,         1'b1};
    vt[12] = '{1'b0, SZ_RSV, 1'b0, 32'h020, 32'h0,         32'h0,         1'b1};
    vt[13] = '{1'b0, SZ_W,   1'b0, 32'h400, 32'h0,         32'h0,         1'b1};
    vt[14] = '{1'b1, SZ_W,   1'b0, 32'h420, 32'hDEADBEEF,  32'h0,         1'b1};
    vt[15] = '{1'b0, SZ_W,   1'b0, 32'h020, 32'h0,         32'h80010000,  1'b0};
    vt[16] = '{1'b0, SZ_B,   1'b0, 32'h011, 32'h0,         32'h00000033,  1'b0};
    vt[17] = '{1'b0, SZ_H,   1'b0, 32'h010, 32'h0,         32'h00003344,  1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    check("rst_init_done", {31'h0, init_done}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init("init");

    // Directed vectors, one at a time
    for (int i = 0; i < 18; i++) begin
      send(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd);
      wait_rsp($sformatf("vec%0d", i), vt[i].exp_d, vt[i].exp_e);
    end

    // Four back-to-back requests: responses on consecutive cycles, store data visible next cycle
    fork
      begin
        send(1'b1, SZ_W, 1'b0, 32'h30, 32'hCAFEBABE);
        send(1'b0, SZ_W, 1'b0, 32'h30, 32'h0);
        send(1'b1, SZ_B, 1'b0, 32'h31, 32'h0000005A);
        send(1'b0, SZ_W, 1'b0, 32'h30, 32'h0);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          bv[i] = rsp_valid;
          bd[i] = rsp_rdata;
        end
      end
    join
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_valid%0d", i), {31'h0, bv[i]}, {31'h0, (i >= 3 && i <= 6)});
    end
    check("b2b_dat0", bd[3], 32'h0);
    check("b2b_dat1", bd[4], 32'hCAFEBABE);
    check("b2b_dat2", bd[5], 32'h0);
    check("b2b_dat3", bd[6], 32'hCAFE5ABE);
    @(posedge clk);
    #1;

    // Randomized traffic scored by the monitor
    for (int k = 0; k < 400; k++) begin
      int          r;
      logic [1:0]  sz;
      logic [31:0] a;
      r  = $urandom_range(0, 19);
      sz = (r < 6) ? SZ_B : (r < 12) ? SZ_H : (r < 19) ? SZ_W : SZ_RSV;
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 63));
      if (sz == SZ_H && $urandom_range(0, 7) != 0) a[0] = 1'b0;
      if (sz == SZ_W && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 24) == 0) a = a | (32'h1 << $urandom_range(10, 31));
      send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(expq.size()), 32'h0);

    // Reset with a load in flight and a store presented on the reset edge
    send(1'b0, SZ_W, 1'b0, 32'h30, 32'h0);
    rst       = 1'b1;
    req_we    = 1'b1;
    req_size  = SZ_W;
    req_addr  = 32'h34;
    req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    nrsp      = 0;
    fork
      wait_init("reinit");
      begin
        repeat (10) begin
          @(negedge clk);
          if (rsp_valid === 1'b1) nrsp++;
        end
      end
    join
    check("midrst_no_rsp", 32'(nrsp), 32'h0);
    send(1'b0, SZ_W, 1'b0, 32'h30, 32'h0);
    wait_rsp("post_rst_30", 32'h0, 1'b0);
    send(1'b0, SZ_W, 1'b0, 32'h34, 32'h0);
    wait_rsp("post_rst_34", 32'h0, 1'b0);
    send(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    wait_rsp("post_rst_10", 32'h0, 1'b0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
